// File: rtl/core_lsu_pkg.sv
// core_lsu_pkg: shared types and constants for the load/store unit.
//   lsu_op_e    - 3-bit load/store operation code
//   lsu_state_e - access sequencing states
//   XLEN        - data path width
package core_lsu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LH  = 3'd1,
    OP_LW  = 3'd2,
    OP_LBU = 3'd3,
    OP_LHU = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } lsu_op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    FIN      = 2'd3
  } lsu_state_e;

  function automatic logic op_is_store(input lsu_op_e op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/core_lsu_align.sv
// core_lsu_align: combinational lane steering for the load/store unit.
//   op_i       - operation code
//   off_i      - byte offset within the word (address bits [1:0])
//   wdata_i    - raw store data (RS2)
//   rdata_i    - raw read word from the bus
//   be_o       - byte enables for the bus request
//   wdata_o    - lane-replicated store data
//   rdata_o    - extracted and sign/zero-extended load value
//   misalign_o - access is not naturally aligned for its size
module core_lsu_align
  import core_lsu_pkg::*;
(
  input  lsu_op_e          op_i,
  input  logic [1:0]       off_i,
  input  logic [XLEN-1:0]  wdata_i,
  input  logic [XLEN-1:0]  rdata_i,
  output logic [3:0]       be_o,
  output logic [XLEN-1:0]  wdata_o,
  output logic [XLEN-1:0]  rdata_o,
  output logic             misalign_o
);

  logic [XLEN-1:0] byte_sh;
  logic [XLEN-1:0] half_sh;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;

  always_comb begin
    // Bring the addressed lane down to bit 0; halves select on bit 1 only
    // so a misaligned half (when not trapped) still reads its enclosing half.
    byte_sh = rdata_i >> {off_i, 3'b000};
    half_sh = rdata_i >> {off_i[1], 4'b0000};
    byte_v  = byte_sh[7:0];
    half_v  = half_sh[15:0];

    rdata_o = rdata_i;
    unique case (op_i)
      OP_LB:   rdata_o = {{(XLEN-8){byte_v[7]}}, byte_v};
      OP_LBU:  rdata_o = {{(XLEN-8){1'b0}}, byte_v};
      OP_LH:   rdata_o = {{(XLEN-16){half_v[15]}}, half_v};
      OP_LHU:  rdata_o = {{(XLEN-16){1'b0}}, half_v};
      default: rdata_o = rdata_i;
    endcase
  end

  always_comb begin
    be_o       = 4'b1111;
    wdata_o    = wdata_i;
    misalign_o = 1'b0;
    unique case (op_i)
      OP_SB: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      OP_SH: begin
        be_o       = off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{wdata_i[15:0]}};
        misalign_o = off_i[0];
      end
      OP_LH, OP_LHU: misalign_o = off_i[0];
      OP_LW, OP_SW:  misalign_o = |off_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/core_lsu.sv
// core_lsu: single-outstanding load/store unit behind the ALU.
//   CLK, RST_N             - clock, synchronous active-low reset
//   START, I_L*/I_S*       - access request pulse and one-hot op flags
//   ADDR, WDATA            - effective address and store data
//   D_REQ_*                - valid/ready data-memory request channel
//   D_RSP_VALID/RDATA      - read response (loads only)
//   BUSY, DONE, MISALIGN   - access status
//   LOAD_DATA              - extended load result, held until the next load
module core_lsu
  import core_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic              I_LB,
  input  logic              I_LH,
  input  logic              I_LW,
  input  logic              I_LBU,
  input  logic              I_LHU,
  input  logic              I_SB,
  input  logic              I_SH,
  input  logic              I_SW,
  input  logic [31:0]       ADDR,
  input  logic [31:0]       WDATA,
  output logic              D_REQ_VALID,
  input  logic              D_REQ_READY,
  output logic [ADDR_W-1:0] D_REQ_ADDR,
  output logic              D_REQ_WE,
  output logic [3:0]        D_REQ_BE,
  output logic [31:0]       D_REQ_WDATA,
  input  logic              D_RSP_VALID,
  input  logic [31:0]       D_RSP_RDATA,
  output logic              BUSY,
  output logic              DONE,
  output logic [31:0]       LOAD_DATA,
  output logic              MISALIGN
);

  lsu_state_e        state_q, state_d;
  lsu_op_e           op_q, op_d;
  logic [1:0]        off_q, off_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       load_q, load_d;
  logic              trap_q, trap_d;

  lsu_op_e           start_op;
  logic              any_flag;
  lsu_op_e           al_op;
  logic [1:0]        al_off;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata;
  logic [31:0]       al_rdata;
  logic              al_mis;

  always_comb begin
    any_flag = I_LB | I_LH | I_LW | I_LBU | I_LHU | I_SB | I_SH | I_SW;
    start_op = OP_LB;
    if      (I_LH)  start_op = OP_LH;
    else if (I_LW)  start_op = OP_LW;
    else if (I_LBU) start_op = OP_LBU;
    else if (I_LHU) start_op = OP_LHU;
    else if (I_SB)  start_op = OP_SB;
    else if (I_SH)  start_op = OP_SH;
    else if (I_SW)  start_op = OP_SW;
  end

  // One aligner serves both directions: in IDLE it sees the incoming op to
  // build BE/store lanes, afterwards the latched op to extract the load lane.
  always_comb begin
    al_op  = (state_q == IDLE) ? start_op   : op_q;
    al_off = (state_q == IDLE) ? ADDR[1:0]  : off_q;
  end

  core_lsu_align u_align (
    .op_i       (al_op),
    .off_i      (al_off),
    .wdata_i    (WDATA),
    .rdata_i    (D_RSP_RDATA),
    .be_o       (al_be),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata),
    .misalign_o (al_mis)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    off_d   = off_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    load_d  = load_q;
    trap_d  = trap_q;
    unique case (state_q)
      IDLE: begin
        if (START && any_flag) begin
          op_d    = start_op;
          off_d   = ADDR[1:0];
          addr_d  = {ADDR[ADDR_W-1:2], 2'b00};
          be_d    = al_be;
          wdata_d = al_wdata;
          trap_d  = CHECK_ALIGN && al_mis;
          state_d = (CHECK_ALIGN && al_mis) ? FIN : REQ;
        end
      end
      REQ: begin
        if (D_REQ_READY) state_d = op_is_store(op_q) ? FIN : WAIT_RSP;
      end
      WAIT_RSP: begin
        if (D_RSP_VALID) begin
          load_d  = al_rdata;
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      op_q    <= OP_LB;
      off_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      load_q  <= '0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      load_q  <= load_d;
      trap_q  <= trap_d;
    end
  end

  always_comb begin
    D_REQ_VALID = (state_q == REQ);
    D_REQ_WE    = (state_q == REQ) && op_is_store(op_q);
    D_REQ_ADDR  = addr_q;
    D_REQ_BE    = be_q;
    D_REQ_WDATA = wdata_q;
    BUSY        = (state_q != IDLE);
    DONE        = (state_q == FIN);
    MISALIGN    = (state_q == FIN) && trap_q;
    LOAD_DATA   = load_q;
  end

endmodule

// File: tb/tb_core_lsu.sv
module tb_core_lsu;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        START;
  logic [7:0]  flags;   // [7]=LB [6]=LH [5]=LW [4]=LBU [3]=LHU [2]=SB [1]=SH [0]=SW
  logic [31:0] ADDR, WDATA;
  logic        D_REQ_VALID, D_REQ_READY, D_REQ_WE;
  logic [31:0] D_REQ_ADDR;
  logic [3:0]  D_REQ_BE;
  logic [31:0] D_REQ_WDATA;
  logic        D_RSP_VALID;
  logic [31:0] D_RSP_RDATA;
  logic        BUSY, DONE, MISALIGN;
  logic [31:0] LOAD_DATA;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] model_load = '0;

  always #5 CLK = ~CLK;

  core_lsu #(.ADDR_W(32), .CHECK_ALIGN(1'b1)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START),
    .I_LB(flags[7]), .I_LH(flags[6]), .I_LW(flags[5]), .I_LBU(flags[4]),
    .I_LHU(flags[3]), .I_SB(flags[2]), .I_SH(flags[1]), .I_SW(flags[0]),
    .ADDR(ADDR), .WDATA(WDATA),
    .D_REQ_VALID(D_REQ_VALID), .D_REQ_READY(D_REQ_READY), .D_REQ_ADDR(D_REQ_ADDR),
    .D_REQ_WE(D_REQ_WE), .D_REQ_BE(D_REQ_BE), .D_REQ_WDATA(D_REQ_WDATA),
    .D_RSP_VALID(D_RSP_VALID), .D_RSP_RDATA(D_RSP_RDATA),
    .BUSY(BUSY), .DONE(DONE), .LOAD_DATA(LOAD_DATA), .MISALIGN(MISALIGN)
  );

  always @(posedge CLK)
    if (START) assert ($countones(flags) <= 1) else $error("op flags not one-hot");

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // op: 0=LB 1=LH 2=LW 3=LBU 4=LHU 5=SB 6=SH 7=SW
  function automatic void ref_model(input int op, input logic [31:0] addr, input logic [31:0] wdata,
                                    input logic [31:0] rdata, output bit mis, output logic [3:0] be,
                                    output logic [31:0] wd, output logic [31:0] ld);
    int off;
    logic [31:0] tmp;
    logic [7:0]  b;
    logic [15:0] h;
    off = int'(addr[1:0]);
    tmp = rdata >> (8 * off);
    b   = tmp[7:0];
    tmp = rdata >> (16 * (off / 2));
    h   = tmp[15:0];
    mis = ((op == 1 || op == 4 || op == 6) && (off % 2 != 0)) || ((op == 2 || op == 7) && off != 0);
    be  = 4'hF;
    wd  = wdata;
    ld  = rdata;
    case (op)
      0: ld = {{24{b[7]}}, b};
      1: ld = {{16{h[15]}}, h};
      3: ld = {24'h0, b};
      4: ld = {16'h0, h};
      5: begin be = 4'(1 << off); wd = {4{wdata[7:0]}}; end
      6: begin be = 4'(3 << (2 * (off / 2))); wd = {2{wdata[15:0]}}; end
      default: ;
    endcase
  endfunction

  task automatic access(input int op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int rdy_dly, input int rsp_dly, input bit poke);
    bit          mis;
    bit          is_st;
    logic [3:0]  ebe;
    logic [31:0] ewd, eld;
    is_st = (op >= 5);
    ref_model(op, addr, wdata, rdata, mis, ebe, ewd, eld);
    START = 1'b1; flags = 8'h80 >> op; ADDR = addr; WDATA = wdata;
    @(posedge CLK); #1;
    START = 1'b0; flags = '0; ADDR = $urandom; WDATA = $urandom;
    if (mis) begin
      check("trap_done", 32'(DONE), 32'd1);
      check("trap_misalign", 32'(MISALIGN), 32'd1);
      check("trap_no_valid", 32'(D_REQ_VALID), 32'd0);
      check("trap_busy", 32'(BUSY), 32'd1);
      check("trap_load_held", LOAD_DATA, model_load);
    end else begin
      for (int k = 0; k <= rdy_dly; k++) begin
        D_REQ_READY = (k == rdy_dly);
        if (poke && k == 0) begin START = 1'b1; flags = 8'h20; ADDR = 32'h0; end
        check("req_valid", 32'(D_REQ_VALID), 32'd1);
        check("req_addr", D_REQ_ADDR, {addr[31:2], 2'b00});
        check("req_we", 32'(D_REQ_WE), 32'(is_st));
        check("req_be", 32'(D_REQ_BE), 32'(ebe));
        if (is_st) check("req_wdata", D_REQ_WDATA, ewd);
        check("req_busy", 32'(BUSY), 32'd1);
        check("req_no_done", 32'(DONE), 32'd0);
        @(posedge CLK); #1;
        START = 1'b0; flags = '0;
      end
      D_REQ_READY = 1'b0;
      check("valid_dropped", 32'(D_REQ_VALID), 32'd0);
      if (!is_st) begin
        for (int j = 0; j < rsp_dly; j++) begin
          check("wait_no_done", 32'(DONE), 32'd0);
          D_RSP_RDATA = $urandom;
          @(posedge CLK); #1;
        end
        D_RSP_VALID = 1'b1; D_RSP_RDATA = rdata;
        @(posedge CLK); #1;
        D_RSP_VALID = 1'b0; D_RSP_RDATA = $urandom;
        model_load = eld;
      end
      check("done", 32'(DONE), 32'd1);
      check("no_misalign", 32'(MISALIGN), 32'd0);
      check("load_data", LOAD_DATA, model_load);
    end
    if (poke) begin START = 1'b1; flags = 8'h20; ADDR = 32'h0; end
    @(posedge CLK); #1;
    START = 1'b0; flags = '0;
    check("idle_after_fin", 32'(BUSY), 32'd0);
    check("done_one_pulse", 32'(DONE), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(D_REQ_VALID), 32'd0);
    check({tag, "_we"},    32'(D_REQ_WE), 32'd0);
    check({tag, "_be"},    32'(D_REQ_BE), 32'd0);
    check({tag, "_addr"},  D_REQ_ADDR, 32'd0);
    check({tag, "_wdata"}, D_REQ_WDATA, 32'd0);
    check({tag, "_busy"},  32'(BUSY), 32'd0);
    check({tag, "_done"},  32'(DONE), 32'd0);
    check({tag, "_mis"},   32'(MISALIGN), 32'd0);
    check({tag, "_load"},  LOAD_DATA, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    RST_N = 1'b0; START = 1'b0; flags = '0; ADDR = '0; WDATA = '0;
    D_REQ_READY = 1'b0; D_RSP_VALID = 1'b0; D_RSP_RDATA = '0;
    repeat (3) @(posedge CLK);
    #1;
    check_all_zero("reset");
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // START with no op flag is ignored
    START = 1'b1; ADDR = 32'h40;
    @(posedge CLK); #1;
    START = 1'b0;
    check("noflag_idle", 32'(BUSY), 32'd0);

    access(2, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0);
    access(0, 32'h0000_1003, 32'h0, 32'h80FF_0011, 0, 0, 1'b0);
    check("lb_sext", LOAD_DATA, 32'hFFFF_FF80);
    access(3, 32'h0000_1003, 32'h0, 32'h80FF_0011, 0, 0, 1'b0);
    check("lbu_zext", LOAD_DATA, 32'h0000_0080);
    access(6, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 3, 0, 1'b0);
    access(2, 32'h0000_3001, 32'h0, 32'h0, 0, 0, 1'b0);
    check("trap_keeps_load", LOAD_DATA, 32'h0000_0080);
    access(5, 32'h0000_0102, 32'h0000_00A5, 32'h0, 1, 0, 1'b1);
    access(4, 32'h0000_0102, 32'h0, 32'h8001_7FFF, 0, 2, 1'b1);

    // Reset abandons an access waiting for its response
    START = 1'b1; flags = 8'h20; ADDR = 32'h0000_4000;
    @(posedge CLK); #1;
    START = 1'b0; flags = '0; D_REQ_READY = 1'b1;
    @(posedge CLK); #1;
    D_REQ_READY = 1'b0;
    check("rst_mid_busy", 32'(BUSY), 32'd1);
    RST_N = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    model_load = '0;
    check_all_zero("midrst");
    D_RSP_VALID = 1'b1; D_RSP_RDATA = 32'h1111_2222;
    @(posedge CLK); #1;
    D_RSP_VALID = 1'b0;
    check("stray_rsp_no_done", 32'(DONE), 32'd0);
    check("stray_rsp_load", LOAD_DATA, 32'd0);
    @(posedge CLK); #1;
    check("stray_rsp_no_done2", 32'(DONE), 32'd0);
    access(2, 32'h0000_5008, 32'h0, 32'hCAFE_F00D, 0, 0, 1'b0);

    for (int i = 0; i < 60; i++)
      access(int'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
